// File: rtl/key_schedule_if.sv
// Key-schedule handshake and read-port bundle.
// start is a request that takes effect only in a cycle where ready=1
// (start & ready = accept, cipher_key sampled on that edge).
// key_valid qualifies key_out/key_round. There is no back-pressure.
// abort cancels a schedule that is in progress.
// rd_round/rd_key form an independent combinational read port.
interface key_schedule_if #(
  parameter int LENGTH = 128
) ();
  logic              start;
  logic [LENGTH-1:0] cipher_key;
  logic              abort;
  logic              ready;
  logic              key_valid;
  logic [LENGTH-1:0] key_out;
  logic [3:0]        key_round;
  logic              done;
  logic [3:0]        rd_round;
  logic [LENGTH-1:0] rd_key;

  modport master (
    output start, cipher_key, abort, rd_round,
    input  ready, key_valid, key_out, key_round, done, rd_key
  );

  modport slave (
    input  start, cipher_key, abort, rd_round,
    output ready, key_valid, key_out, key_round, done, rd_key
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: presents one round key per cycle,
// starting with round 0 (the cipher key itself) and ending with round ROUNDS.
// The round function works on the AES-128 word layout (word 0 in [127:96]),
// so LENGTH is expected to stay at 128.
// Optional macro KEY_SCHED_STORE_EN builds a (ROUNDS+1)-entry round-key store
// with per-entry valid bits behind the rd_round/rd_key read port.
module key_schedule_ctrl #(
  parameter int LENGTH = 128,
  parameter int ROUNDS = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  key_schedule_if.slave  bus,
  output logic           state_dbg
);

  localparam logic [3:0] LAST = 4'(ROUNDS);

  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t            state;
  logic              ready;
  logic              key_valid;
  logic              done;
  logic [LENGTH-1:0] key_out;
  logic [3:0]        key_round;

  logic [3:0]        next_round;
  logic [LENGTH-1:0] next_key;
  logic              accept;
  logic              step;

  // GF(2^8) multiply with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int i = 2; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for round r (1-based): 01,02,04,...,80,1b,36.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < 16; i++) begin
      if (4'(i) < r) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
    end
    return c;
  endfunction

  // One KeyExpansion round: previous round key in, round key r out.
  function automatic logic [LENGTH-1:0] expand_round(input logic [LENGTH-1:0] k,
                                                     input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;
    w0   = k[127:96];
    w1   = k[95:64];
    w2   = k[63:32];
    w3   = k[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^
           {rcon(r), 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // The single expansion instance always works from the registered key.
  always_comb begin
    next_round = key_round + 4'd1;
    next_key   = expand_round(key_out, next_round);
    accept     = (state == IDLE) && bus.start && !bus.abort;
    step       = (state == EXPAND) && !bus.abort && (key_round != LAST);
  end

  // Control FSM with registered outputs; leaving EXPAND clears valid/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      key_valid <= 1'b0;
      done      <= 1'b0;
      key_out   <= '0;
      key_round <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= EXPAND;
            ready     <= 1'b0;
            key_valid <= 1'b1;
            key_out   <= bus.cipher_key;
            key_round <= '0;
            done      <= (LAST == 4'd0);
          end
        end
        EXPAND: begin
          if (bus.abort || key_round == LAST) begin
            state     <= IDLE;
            ready     <= 1'b1;
            key_valid <= 1'b0;
            done      <= 1'b0;
          end else begin
            key_out   <= next_key;
            key_round <= next_round;
            done      <= (next_round == LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_SCHED_STORE_EN
  logic [LENGTH-1:0] store_mem [ROUNDS+1];
  logic [ROUNDS:0]   store_vld;
  logic [3:0]        wr_idx;
  logic [LENGTH-1:0] wr_data;

  // Entries are written as the key is loaded into key_out, so an entry is
  // readable in the same cycle its key is presented.
  always_comb begin
    wr_idx  = accept ? 4'd0 : next_round;
    wr_data = accept ? bus.cipher_key : next_key;
  end

  // Valid bits: cleared on every accepted start and by reset; survive abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_vld <= '0;
    end else if (accept) begin
      store_vld    <= '0;
      store_vld[0] <= 1'b1;
    end else if (step) begin
      store_vld[wr_idx] <= 1'b1;
    end
  end

  // Store data needs no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (accept || step) store_mem[wr_idx] <= wr_data;
  end

  // Out-of-range or never-written entries read as zero.
  always_comb begin
    bus.rd_key = '0;
    if (bus.rd_round <= LAST && store_vld[bus.rd_round]) bus.rd_key = store_mem[bus.rd_round];
  end
`else
  logic unused_rd;
  assign unused_rd  = ^bus.rd_round;
  assign bus.rd_key = '0;
`endif

  assign bus.ready     = ready;
  assign bus.key_valid = key_valid;
  assign bus.done      = done;
  assign bus.key_out   = key_out;
  assign bus.key_round = key_round;
  assign state_dbg     = (state == EXPAND);

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl against the FIPS-197 AES-128 example.
// Inputs change and outputs are sampled on the falling edge.
module tb_key_schedule_ctrl;

  logic clk;
  logic rst_n;
  logic state_dbg;
  int   checks;
  int   errors;

  logic [127:0] exp_q[$];
  logic [127:0] fips_keys [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] zero_r1  = 128'h62636363626363636263636362636363;
  logic [127:0] zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_schedule_if #(.LENGTH(128)) bus ();

  key_schedule_ctrl #(.LENGTH(128), .ROUNDS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: request a schedule; returns at the falling edge where round 0 shows.
  task automatic drive_start(input logic [127:0] key);
    bus.start      = 1'b1;
    bus.cipher_key = key;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.cipher_key = '0; bus.rd_round = 4'd0;
    repeat (2) @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.key_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.key_out !== 128'h0) begin errors++; $display("FAIL reset_key: got %h want 0", bus.key_out); end
    checks++; if (bus.key_round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d want 0", bus.key_round); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", state_dbg); end
    checks++; if (bus.rd_key !== 128'h0) begin errors++; $display("FAIL reset_rd_key: got %h want 0", bus.rd_key); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    logic [127:0] exp_key;
    for (int r = 0; r <= 10; r++) exp_q.push_back(fips_keys[r]);
    drive_start(fips_key);
    for (int r = 0; r <= 10; r++) begin
      exp_key = exp_q.pop_front();
      checks++; if (bus.key_round !== 4'(r)) begin errors++; $display("FAIL run_round: got %0d want %0d", bus.key_round, r); end
      checks++; if (bus.key_out !== exp_key) begin errors++; $display("FAIL run_key r%0d: got %h want %h", r, bus.key_out, exp_key); end
      checks++; if (bus.key_valid !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL run_valid_ready r%0d: got %b%b want 10", r, bus.key_valid, bus.ready); end
      checks++; if (bus.done !== (r == 10)) begin errors++; $display("FAIL run_done r%0d: got %b want %b", r, bus.done, (r == 10)); end
      @(negedge clk);
    end
    checks++; if (bus.ready !== 1'b1 || bus.key_valid !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL run_end: got ready %b valid %b done %b want 1 0 0", bus.ready, bus.key_valid, bus.done); end
    for (int r = 0; r <= 12; r++) begin
      if (r == 11) continue;
      bus.rd_round = 4'(r);
      #1;
`ifdef KEY_SCHED_STORE_EN
      exp_key = (r <= 10) ? fips_keys[r] : 128'h0;
`else
      exp_key = 128'h0;
`endif
      checks++; if (bus.rd_key !== exp_key) begin errors++; $display("FAIL store_read r%0d: got %h want %h", r, bus.rd_key, exp_key); end
    end
    bus.rd_round = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    drive_start(fips_key);
    for (int r = 0; r <= 10; r++) begin
      checks++; if (bus.key_out !== fips_keys[r]) begin errors++; $display("FAIL ign_key r%0d: got %h want %h", r, bus.key_out, fips_keys[r]); end
      if (r == 5) begin bus.start = 1'b1; bus.cipher_key = 128'h00112233445566778899aabbccddeeff; end
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++; if (bus.ready !== 1'b1 || bus.key_valid !== 1'b0) begin errors++; $display("FAIL ign_end: got ready %b valid %b want 1 0", bus.ready, bus.key_valid); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int seen_done;
    drive_start(fips_key);
    repeat (4) @(negedge clk);
    checks++; if (bus.key_round !== 4'd4) begin errors++; $display("FAIL abort_pre_round: got %0d want 4", bus.key_round); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.ready !== 1'b1 || bus.key_valid !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_next: got ready %b valid %b done %b want 1 0 0", bus.ready, bus.key_valid, bus.done); end
    bus.rd_round = 4'd3; #1;
`ifdef KEY_SCHED_STORE_EN
    checks++; if (bus.rd_key !== fips_keys[3]) begin errors++; $display("FAIL abort_rd3: got %h want %h", bus.rd_key, fips_keys[3]); end
`else
    checks++; if (bus.rd_key !== 128'h0) begin errors++; $display("FAIL abort_rd3: got %h want 0", bus.rd_key); end
`endif
    bus.rd_round = 4'd6; #1;
    checks++; if (bus.rd_key !== 128'h0) begin errors++; $display("FAIL abort_rd6: got %h want 0", bus.rd_key); end
    // abort together with start in IDLE: nothing starts, store untouched
    bus.start = 1'b1; bus.abort = 1'b1; bus.cipher_key = '0;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    checks++; if (bus.ready !== 1'b1 || bus.key_valid !== 1'b0 || state_dbg !== 1'b0) begin errors++; $display("FAIL abort_idle_start: got ready %b valid %b state %b want 1 0 0", bus.ready, bus.key_valid, state_dbg); end
    bus.rd_round = 4'd3; #1;
`ifdef KEY_SCHED_STORE_EN
    checks++; if (bus.rd_key !== fips_keys[3]) begin errors++; $display("FAIL abort_idle_rd3: got %h want %h", bus.rd_key, fips_keys[3]); end
`endif
    seen_done = 0;
    repeat (12) begin @(negedge clk); if (bus.done === 1'b1) seen_done++; end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); end
    // abort on the round-10 cycle: done still shows, then IDLE
    drive_start(fips_key);
    repeat (10) @(negedge clk);
    bus.abort = 1'b1;
    checks++; if (bus.done !== 1'b1 || bus.key_round !== 4'd10) begin errors++; $display("FAIL abort_last_done: got done %b round %0d want 1 10", bus.done, bus.key_round); end
    @(negedge clk);
    bus.abort = 1'b0;
    checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_last_idle: got ready %b done %b want 1 0", bus.ready, bus.done); end
    bus.rd_round = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    drive_start(fips_key);
    repeat (7) @(negedge clk);
    checks++; if (bus.key_round !== 4'd7) begin errors++; $display("FAIL rstmid_pre_round: got %0d want 7", bus.key_round); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ready !== 1'b1 || bus.key_valid !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got ready %b valid %b done %b want 1 0 0", bus.ready, bus.key_valid, bus.done); end
    checks++; if (bus.key_out !== 128'h0 || bus.key_round !== 4'd0) begin errors++; $display("FAIL rstmid_key: got %h r%0d want 0 r0", bus.key_out, bus.key_round); end
    checks++; if (bus.rd_key !== 128'h0) begin errors++; $display("FAIL rstmid_store: got %h want 0", bus.rd_key); end
    seen_done = 0;
    repeat (5) begin @(negedge clk); if (bus.done === 1'b1) seen_done++; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (bus.done === 1'b1) seen_done++; end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen_done); end
    drive_start(fips_key);
    @(negedge clk);
    checks++; if (bus.key_round !== 4'd1 || bus.key_out !== fips_keys[1]) begin errors++; $display("FAIL rstmid_r1: got r%0d %h want r1 %h", bus.key_round, bus.key_out, fips_keys[1]); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive_start(fips_key);
    repeat (10) @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", bus.done); end
    @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b want 1", bus.ready); end
    drive_start(128'h0);
    checks++; if (bus.key_valid !== 1'b1 || bus.key_out !== 128'h0) begin errors++; $display("FAIL b2b_r0: got valid %b %h want 1 0", bus.key_valid, bus.key_out); end
    @(negedge clk);
    checks++; if (bus.key_out !== zero_r1) begin errors++; $display("FAIL b2b_r1: got %h want %h", bus.key_out, zero_r1); end
    repeat (9) @(negedge clk);
    checks++; if (bus.key_out !== zero_r10 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_r10: got %h done %b want %h 1", bus.key_out, bus.done, zero_r10); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    @(negedge clk);
    test_reset();
    test_full_run();
    test_ignored_start();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
